// File: rtl/kuznechik_codec.sv
// kuznechik_codec: iterative GOST R 34.12-2015 (Kuznechik) 128-bit block codec with runtime round keys
// Ports: clk_i/resetn_i clock and async active-low reset; key_we_i/key_idx_i/key_i round-key write
// (index 0..9 = K1..K10); request_i/decrypt_i/data_i start a block; ack_i consumes the result;
// busy_o core not idle; valid_o/data_o result block held until ack_i.
module kuznechik_codec #(
    parameter int L_STEPS_PER_CYCLE = 1,
    parameter bit DECRYPT_EN        = 1'b1
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic         key_we_i,
    input  logic [3:0]   key_idx_i,
    input  logic [127:0] key_i,
    input  logic         request_i,
    input  logic         decrypt_i,
    input  logic [127:0] data_i,
    input  logic         ack_i,
    output logic         busy_o,
    output logic         valid_o,
    output logic [127:0] data_o
);
    // KEYADD is folded into SUB (decrypt) so it has no encoding of its own
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SUB  = 3'd2;
    localparam logic [2:0] LIN  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [3:0] LIN_LAST = 4'(16 / L_STEPS_PER_CYCLE - 1);

    if (L_STEPS_PER_CYCLE != 1 && L_STEPS_PER_CYCLE != 2 && L_STEPS_PER_CYCLE != 4 &&
        L_STEPS_PER_CYCLE != 8 && L_STEPS_PER_CYCLE != 16) begin : g_bad_steps
        $error("L_STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // pi table, entry 0 in the top byte
    localparam logic [2047:0] PI = {
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // coefficients of l, a15 in the top byte
    localparam logic [127:0] LCOEF = {8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                                      8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};

    function automatic logic [2047:0] invert(input logic [2047:0] t);
        logic [2047:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) r[{~t[{~i[7:0], 3'b000} +: 8], 3'b000} +: 8] = i[7:0];
        return r;
    endfunction

    localparam logic [2047:0] PI_INV = invert(PI);

    function automatic logic [127:0] sub(input logic [127:0] x, input logic [2047:0] t);
        logic [127:0] y;
        for (int j = 0; j < 16; j++) y[8*j +: 8] = t[{~x[8*j +: 8], 3'b000} +: 8];
        return y;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] lfun(input logic [127:0] w);
        logic [7:0] s;
        s = '0;
        for (int j = 0; j < 16; j++) s ^= gmul(w[8*j +: 8], LCOEF[8*j +: 8]);
        return s;
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] a);
        return {lfun(a), a[127:8]};
    endfunction

    function automatic logic [127:0] inv_step(input logic [127:0] a);
        return {a[119:0], lfun({a[119:0], a[127:120]})};
    endfunction

    logic [2:0]   r_state;
    logic         r_dec;
    logic [3:0]   r_rnd;
    logic [3:0]   r_cnt;
    logic [127:0] r_st;
    logic [127:0] r_data;
    logic [127:0] r_key [10];

    logic [127:0] w_chain_f [L_STEPS_PER_CYCLE+1];
    logic [127:0] w_s, w_si, w_linv, w_lin, w_k;
    logic         w_dec, w_accept, w_last;

    assign w_chain_f[0] = r_st;
    for (genvar g = 0; g < L_STEPS_PER_CYCLE; g++) begin : g_fwd
        assign w_chain_f[g+1] = fwd_step(w_chain_f[g]);
    end

    if (DECRYPT_EN) begin : g_inv
        logic [127:0] w_chain_i [L_STEPS_PER_CYCLE+1];
        assign w_chain_i[0] = r_st;
        for (genvar g = 0; g < L_STEPS_PER_CYCLE; g++) begin : g_step
            assign w_chain_i[g+1] = inv_step(w_chain_i[g]);
        end
        assign w_linv = w_chain_i[L_STEPS_PER_CYCLE];
        assign w_si   = sub(r_st, PI_INV);
    end else begin : g_no_inv
        assign w_linv = '0;
        assign w_si   = '0;
    end

    assign w_s      = sub(r_st, PI);
    assign w_dec    = DECRYPT_EN && decrypt_i;
    // decrypt consumes K(r) in SUB, encrypt consumes K(r+1) at the end of LIN
    assign w_k      = r_dec ? r_key[r_rnd - 4'd1] : r_key[r_rnd];
    assign w_lin    = r_dec ? w_linv : w_chain_f[L_STEPS_PER_CYCLE];
    assign w_last   = r_cnt == LIN_LAST;
    assign w_accept = request_i && (r_state == IDLE || (r_state == DONE && ack_i));
    assign busy_o   = r_state != IDLE;
    assign valid_o  = r_state == DONE;
    assign data_o   = r_data;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= IDLE;
            r_dec   <= 1'b0;
            r_rnd   <= '0;
            r_cnt   <= '0;
            r_st    <= '0;
            r_data  <= '0;
            for (int i = 0; i < 10; i++) r_key[i] <= '0;
        end else begin
            if (key_we_i && !busy_o && key_idx_i < 4'd10) r_key[key_idx_i] <= key_i;
            if (w_accept) begin
                r_dec   <= w_dec;
                r_st    <= data_i ^ (w_dec ? r_key[9] : r_key[0]);
                r_rnd   <= w_dec ? 4'd9 : 4'd1;
                r_cnt   <= '0;
                r_state <= w_dec ? LIN : SUB;
            end else if (r_state == DONE && ack_i) begin
                r_state <= IDLE;
            end else if (r_state == SUB) begin
                if (r_dec) begin
                    r_st    <= w_si ^ w_k;
                    r_rnd   <= r_rnd - 4'd1;
                    r_state <= r_rnd == 4'd1 ? DONE : LIN;
                    if (r_rnd == 4'd1) r_data <= w_si ^ w_k;
                end else begin
                    r_st    <= w_s;
                    r_state <= LIN;
                end
            end else if (r_state == LIN) begin
                r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
                if (!w_last || r_dec) r_st <= w_lin;
                if (w_last && r_dec) r_state <= SUB;
                if (w_last && !r_dec) begin
                    r_st    <= w_lin ^ w_k;
                    r_rnd   <= r_rnd + 4'd1;
                    r_state <= r_rnd == 4'd9 ? DONE : SUB;
                    if (r_rnd == 4'd9) r_data <= w_lin ^ w_k;
                end
            end
        end
    end
endmodule
